seq_mac: RTL and testbench

Parametrised sequential multiply-accumulate unit for the MAC datapath. It is an iterative shift-add multiplier with early termination on a zero multiplier, and it supports signed and unsigned operands. The result goes into a wide accumulator with sticky overflow detection. The block uses a start/ready/done handshake so a host sequencer can stream operand pairs.

---
 rtl/seq_mac_pkg.sv | 31 +++
 rtl/seq_mac_if.sv | 31 +++
 rtl/seq_mac_mul_core.sv | 57 +++++
 rtl/seq_mac.sv | 172 +++++++++++++++++
 tb/tb_seq_mac.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/seq_mac_pkg.sv
// Shared types and helpers for the sequential multiply-accumulate unit.
// Holds the controller state encoding, default widths and the sign-extension helper.
package mac_pkg;

   localparam int N_DEF     = 32;
   localparam int ACC_W_DEF = 2 * N_DEF + 8;
   // Widest value the sign-extension helper can carry; ACC_W must not exceed it.
   localparam int EXT_W     = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      FIN  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Replicates bit w-1 of v into every higher bit position.
   function automatic logic [EXT_W-1:0] sign_ext(input logic [EXT_W-1:0] v, input int w);
      logic [EXT_W-1:0] r;
      r = v;
      for (int i = 0; i < EXT_W; i++) begin
         if (i >= w) begin
            r[i] = v[w-1];
         end else begin
            r[i] = v[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_mac_if.sv
// Host-side start/ready/done handshake and result bus of the multiply-accumulate unit.
interface seq_mac_if
   import mac_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int ACC_W = 2 * N + 8
) ();

   logic             start;
   logic             signed_mode;
   logic             accumulate;
   logic             clear;
   logic [N-1:0]     a;
   logic [N-1:0]     b;
   logic             ready;
   logic             done;
   logic [2*N-1:0]   product;
   logic [ACC_W-1:0] acc;
   logic             overflow;

   modport master (
      output start, signed_mode, accumulate, clear, a, b,
      input  ready, done, product, acc, overflow
   );

   modport slave (
      input  start, signed_mode, accumulate, clear, a, b,
      output ready, done, product, acc, overflow
   );

endinterface

// File: rtl/seq_mac_mul_core.sv
// Magnitude shift-add engine: one multiplier bit per enabled cycle on unsigned operands.
// mb_last tells the controller the current iteration is the final one.
module mac_mul_core
   import mac_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           enable,
   input  logic [2*N-1:0] ma_init,
   input  logic [N-1:0]   mb_init,
   output logic [2*N-1:0] psum,
   output logic           mb_last
);

   logic [2*N-1:0] ma_r;
   logic [N-1:0]   mb_r;
   logic [2*N-1:0] p_r;
   logic [2*N-1:0] addend_s;

   // Selects the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      addend_s = {(2*N){1'b0}};
      if (mb_r[0]) begin
         addend_s = ma_r;
      end else begin
         addend_s = {(2*N){1'b0}};
      end
   end

   // Operand load and one shift-add iteration per enabled cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ma_r <= {(2*N){1'b0}};
         mb_r <= {N{1'b0}};
         p_r  <= {(2*N){1'b0}};
      end else if (load) begin
         ma_r <= ma_init;
         mb_r <= mb_init;
         p_r  <= {(2*N){1'b0}};
      end else if (enable) begin
         ma_r <= {ma_r[2*N-2:0], 1'b0};
         mb_r <= {1'b0, mb_r[N-1:1]};
         p_r  <= p_r + addend_s;
      end else begin
         ma_r <= ma_r;
         mb_r <= mb_r;
         p_r  <= p_r;
      end
   end

   assign psum    = p_r;
   assign mb_last = ~(|mb_r[N-1:1]);

endmodule

// File: rtl/seq_mac.sv
// Sequential signed/unsigned multiply-accumulate unit with sticky accumulator overflow.
// Controller, sign fix-up and accumulator live here; the shift-add engine is mac_mul_core.
module seq_mac
   import mac_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input logic     clk,
   input logic     reset,
   seq_mac_if.slave bus
);

   localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_nx_s;
   logic             neg_r;
   logic             sgn_r;
   logic             accum_r;
   logic [2*N-1:0]   product_r;
   logic [ACC_W-1:0] acc_r;
   logic             ovf_r;
   logic             done_r;
   logic             ready_r;

   logic [N-1:0]     a_mag_s;
   logic [N-1:0]     b_mag_s;
   logic             neg_s;
   logic             load_s;
   logic             enable_s;
   logic [2*N-1:0]   psum_s;
   logic             mb_last_s;
   logic [2*N-1:0]   prod_s;
   logic [ACC_W-1:0] ext_s;
   logic [ACC_W:0]   sum_s;
   logic             ovf_add_s;

   // Operand magnitudes and result sign; two's-complement only in signed mode.
   always_comb begin
      a_mag_s = bus.a;
      b_mag_s = bus.b;
      neg_s   = 1'b0;
      if (bus.signed_mode) begin
         a_mag_s = bus.a[N-1] ? (~bus.a + ONE_N) : bus.a;
         b_mag_s = bus.b[N-1] ? (~bus.b + ONE_N) : bus.b;
         neg_s   = bus.a[N-1] ^ bus.b[N-1];
      end else begin
         a_mag_s = bus.a;
         b_mag_s = bus.b;
         neg_s   = 1'b0;
      end
   end

   mac_mul_core #(.N(N)) u_core (
      .clk     (clk),
      .reset   (reset),
      .load    (load_s),
      .enable  (enable_s),
      .ma_init ({{N{1'b0}}, a_mag_s}),
      .mb_init (b_mag_s),
      .psum    (psum_s),
      .mb_last (mb_last_s)
   );

   // Next-state and engine control; a zero multiplier skips straight to FIN.
   always_comb begin
      state_nx_s = state_r;
      load_s     = 1'b0;
      enable_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               load_s     = 1'b1;
               state_nx_s = (|b_mag_s) ? MUL : FIN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         MUL: begin
            enable_s = 1'b1;
            if (mb_last_s) begin
               state_nx_s = FIN;
            end else begin
               state_nx_s = MUL;
            end
         end
         FIN:     state_nx_s = DONE;
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Mode latches captured with the operands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         neg_r   <= 1'b0;
         sgn_r   <= 1'b0;
         accum_r <= 1'b0;
      end else if (load_s) begin
         neg_r   <= neg_s;
         sgn_r   <= bus.signed_mode;
         accum_r <= bus.accumulate;
      end else begin
         neg_r   <= neg_r;
         sgn_r   <= sgn_r;
         accum_r <= accum_r;
      end
   end

   // Signed product, its accumulator-width extension, and the sum with overflow.
   always_comb begin
      prod_s    = neg_r ? (~psum_s + ONE_2N) : psum_s;
      ext_s     = {ACC_W{1'b0}};
      ovf_add_s = 1'b0;
      if (sgn_r) begin
         ext_s = ACC_W'(sign_ext(EXT_W'(prod_s), 2 * N));
      end else begin
         ext_s = ACC_W'(prod_s);
      end
      sum_s = {1'b0, acc_r} + {1'b0, ext_s};
      if (sgn_r) begin
         ovf_add_s = (acc_r[ACC_W-1] == ext_s[ACC_W-1]) && (sum_s[ACC_W-1] != acc_r[ACC_W-1]);
      end else begin
         ovf_add_s = sum_s[ACC_W];
      end
   end

   // Result registers and handshake flags; clear is only honoured while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         product_r <= {(2*N){1'b0}};
         acc_r     <= {ACC_W{1'b0}};
         ovf_r     <= 1'b0;
         done_r    <= 1'b0;
         ready_r   <= 1'b1;
      end else begin
         done_r  <= (state_nx_s == DONE);
         ready_r <= (state_nx_s == IDLE);
         if (state_r == FIN) begin
            product_r <= prod_s;
            acc_r     <= accum_r ? sum_s[ACC_W-1:0] : ext_s;
            ovf_r     <= ovf_r | (accum_r & ovf_add_s);
         end else if ((state_r == IDLE) && bus.clear) begin
            product_r <= product_r;
            acc_r     <= {ACC_W{1'b0}};
            ovf_r     <= 1'b0;
         end else begin
            product_r <= product_r;
            acc_r     <= acc_r;
            ovf_r     <= ovf_r;
         end
      end
   end

   assign bus.ready    = ready_r;
   assign bus.done     = done_r;
   assign bus.product  = product_r;
   assign bus.acc      = acc_r;
   assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_seq_mac.sv
// Directed-vector bench for seq_mac with N=8, ACC_W=24; expected values are hand-computed.
module tb_seq_mac;

   localparam int N     = 8;
   localparam int ACC_W = 24;

   logic clk = 1'b0;
   logic reset;
   int   n_vec  = 0;
   int   n_miss = 0;
   int   lat;
   int   rdy_hi;
   int   dones;

   seq_mac_if #(.N(N), .ACC_W(ACC_W)) bus ();

   seq_mac #(.N(N), .ACC_W(ACC_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one operation, scrambles the operands after the start edge and waits for done.
   task automatic run_op(input logic sm, input logic ac, input logic cl,
                         input logic [7:0] av, input logic [7:0] bv,
                         output int lat_o, output int rdy_o);
      logic seen;
      @(negedge clk);
      bus.start       = 1'b1;
      bus.signed_mode = sm;
      bus.accumulate  = ac;
      bus.clear       = cl;
      bus.a           = av;
      bus.b           = bv;
      seen  = 1'b0;
      lat_o = 0;
      rdy_o = 0;
      while (!seen && lat_o < 100) begin
         @(negedge clk);
         lat_o++;
         if (bus.ready) rdy_o++;
         if (bus.done) seen = 1'b1;
         bus.start = 1'b0;
         bus.clear = 1'b0;
         bus.a     = ~av;
         bus.b     = ~bv;
      end
      if (!seen) chk("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      reset           = 1'b1;
      bus.start       = 1'b0;
      bus.signed_mode = 1'b0;
      bus.accumulate  = 1'b0;
      bus.clear       = 1'b0;
      bus.a           = 8'd0;
      bus.b           = 8'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_ready", 64'(bus.ready), 64'd1);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_product", 64'(bus.product), 64'd0);
      chk("rst_acc", 64'(bus.acc), 64'd0);
      chk("rst_ovf", 64'(bus.overflow), 64'd0);

      run_op(1'b0, 1'b0, 1'b0, 8'd200, 8'd150, lat, rdy_hi);
      chk("u_lat", 64'(lat), 64'd10);
      chk("u_ready_low", 64'(rdy_hi), 64'd0);
      chk("u_product", 64'(bus.product), 64'h7530);
      chk("u_acc", 64'(bus.acc), 64'h007530);

      run_op(1'b1, 1'b0, 1'b0, 8'h80, 8'h80, lat, rdy_hi);
      chk("s_minmin_product", 64'(bus.product), 64'h4000);
      chk("s_minmin_lat", 64'(lat), 64'd10);
      run_op(1'b1, 1'b0, 1'b0, 8'hFD, 8'd5, lat, rdy_hi);
      chk("s_neg_product", 64'(bus.product), 64'hFFF1);
      chk("s_neg_acc", 64'(bus.acc), 64'hFFFFF1);
      run_op(1'b1, 1'b1, 1'b0, 8'd3, 8'd5, lat, rdy_hi);
      chk("s_accum_acc", 64'(bus.acc), 64'h000000);
      chk("s_accum_ovf", 64'(bus.overflow), 64'd0);

      run_op(1'b0, 1'b0, 1'b0, 8'd5, 8'd0, lat, rdy_hi);
      chk("b0_product", 64'(bus.product), 64'd0);
      chk("b0_lat", 64'(lat), 64'd2);
      run_op(1'b0, 1'b0, 1'b0, 8'hFF, 8'd1, lat, rdy_hi);
      chk("b1_product", 64'(bus.product), 64'h00FF);
      chk("b1_lat", 64'(lat), 64'd3);

      run_op(1'b0, 1'b0, 1'b0, 8'd255, 8'd255, lat, rdy_hi);
      for (int i = 0; i < 257; i++) run_op(1'b0, 1'b1, 1'b0, 8'd255, 8'd255, lat, rdy_hi);
      chk("ov258_acc", 64'(bus.acc), 64'hFFFD02);
      chk("ov258_ovf", 64'(bus.overflow), 64'd0);
      run_op(1'b0, 1'b1, 1'b0, 8'd255, 8'd255, lat, rdy_hi);
      chk("ov259_acc", 64'(bus.acc), 64'h00FB03);
      chk("ov259_ovf", 64'(bus.overflow), 64'd1);
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      chk("clr_acc", 64'(bus.acc), 64'd0);
      chk("clr_ovf", 64'(bus.overflow), 64'd0);

      // Second start pulse while multiplying must not launch another operation.
      @(negedge clk);
      bus.start      = 1'b1;
      bus.accumulate = 1'b0;
      bus.a          = 8'd200;
      bus.b          = 8'd150;
      dones          = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (bus.done) dones++;
         bus.start = (c == 3);
      end
      chk("mid_start_dones", 64'(dones), 64'd1);
      chk("mid_start_product", 64'(bus.product), 64'h7530);

      run_op(1'b0, 1'b1, 1'b1, 8'd7, 8'd9, lat, rdy_hi);
      chk("clr_start_acc", 64'(bus.acc), 64'h00003F);
      chk("clr_start_ovf", 64'(bus.overflow), 64'd0);

      @(negedge clk);
      bus.start      = 1'b1;
      bus.accumulate = 1'b1;
      bus.a          = 8'd200;
      bus.b          = 8'd150;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_acc", 64'(bus.acc), 64'd0);
      chk("abort_product", 64'(bus.product), 64'd0);
      chk("abort_done", 64'(bus.done), 64'd0);
      chk("abort_ready", 64'(bus.ready), 64'd1);
      run_op(1'b0, 1'b0, 1'b0, 8'd2, 8'd3, lat, rdy_hi);
      chk("post_abort_product", 64'(bus.product), 64'd6);
      chk("post_abort_acc", 64'(bus.acc), 64'd6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
